// File: rtl/serializer8_com.sv
// MSB-first byte serializer with COM idle fill and post-reset link sync.
// One-entry holding buffer lets upstream hand over a byte at any phase.
module serializer8_com #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_out,
  output logic       sym_start,
  output logic       active
);

  localparam logic ST_SYNC   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  logic       state;
  logic       state_nxt;
  logic [2:0] bitcnt;
  logic [3:0] sync_cnt;
  logic [7:0] sh;
  logic [7:0] hold;
  logic       hold_full;
  logic       last_bit;
  logic       accept;

  assign last_bit = (bitcnt == 3'd7);
  assign in_ready = reset & (state == ST_ACTIVE)
                  & (~hold_full | last_bit);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    if (state == ST_SYNC && last_bit &&
        sync_cnt == SYNC_LAST)
      state_nxt = ST_ACTIVE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      bitcnt    <= 3'd0;
      sync_cnt  <= 4'd0;
      sh        <= COM_SYMBOL;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      ser_out   <= 1'b0;
      sym_start <= 1'b0;
      active    <= 1'b0;
    end else begin
      bitcnt    <= bitcnt + 3'd1;
      ser_out   <= sh[3'd7 - bitcnt];
      sym_start <= (bitcnt == 3'd0);
      state     <= state_nxt;
      active    <= (state_nxt == ST_ACTIVE);
      if (state == ST_SYNC && last_bit)
        sync_cnt <= sync_cnt + 4'd1;
      // Older buffered byte always goes out before a new one.
      if (last_bit) begin
        if (hold_full)
          sh <= hold;
        else if (accept)
          sh <= in_data;
        else
          sh <= COM_SYMBOL;
      end
      if (accept && (hold_full || !last_bit)) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end else if (last_bit) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serializer8_com.sv
// Bench for serializer8_com: symbol-level queue model of the
// transmitted stream, directed scenarios plus random traffic.
module tb_serializer8_com;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         SYNC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_out;
  logic       sym_start;
  logic       active;

  int checks = 0;
  int failures = 0;

  // n: edges since reset release; syms: symbols on the line in
  // order; fifo: accepted bytes not yet started on the line.
  int         n;
  logic [7:0] fifo[$];
  logic [7:0] syms[$];

  serializer8_com #(.COM_SYMBOL(COM), .SYNC_COUNT(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ser_out(ser_out),
    .sym_start(sym_start),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b n=%0d",
             tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    fifo.delete();
    syms.delete();
    syms.push_back(COM);
  endtask

  function automatic logic model_active();
    return n >= 8 * SYNC;
  endfunction

  function automatic logic model_ready();
    return model_active() && (fifo.size() == 0 || n % 8 == 7);
  endfunction

  task automatic check_outputs();
    logic [7:0] s;
    int p;
    if (n == 0) begin
      check("ser_out", ser_out, 1'b0);
      check("sym_start", sym_start, 1'b0);
    end else begin
      p = (n - 1) % 8;
      s = syms[(n - 1) / 8];
      check("ser_out", ser_out, s[7 - p]);
      check("sym_start", sym_start, p == 0);
    end
    check("active", active, model_active());
    check("in_ready", in_ready, model_ready());
  endtask

  task automatic check_reset_outputs();
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_sym_start", sym_start, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
  endtask

  // Called just after a falling edge; advances exactly one cycle.
  task automatic step(logic v, logic [7:0] d);
    check_outputs();
    in_valid = v;
    in_data  = d;
    if (v && model_ready())
      fifo.push_back(d);
    if (n % 8 == 7)
      syms.push_back(fifo.size() != 0 ? fifo.pop_front() : COM);
    n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++)
      step(1'b0, 8'($urandom));
  endtask

  task automatic align(int ph);
    while (n % 8 != ph)
      step(1'b0, 8'($urandom));
  endtask

  task automatic rand_steps(int k);
    for (int i = 0; i < k; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  initial begin
    logic [7:0] stream[3];
    int sent;
    stream[0] = 8'h12;
    stream[1] = 8'h34;
    stream[2] = 8'h56;

    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;

    // Sync run with junk on the inputs, then idle COM.
    rand_steps(8 * SYNC);
    idle(16);

    // Buffered byte presented mid-symbol.
    align(3);
    step(1'b1, 8'hA5);
    idle(20);

    // Bypass byte in the last-bit cycle.
    align(7);
    step(1'b1, 8'h3C);
    idle(16);

    // Back-to-back stream with valid held high.
    align(2);
    sent = 0;
    while (sent < 3) begin
      if (model_ready()) begin
        step(1'b1, stream[sent]);
        sent++;
      end else begin
        step(1'b1, stream[sent]);
      end
    end
    idle(32);

    // Payload equal to COM, then zero.
    align(7);
    step(1'b1, 8'hBC);
    align(7);
    step(1'b1, 8'h00);
    idle(16);

    rand_steps(400);

    // Reset mid-symbol with a byte shifting and one buffered.
    idle(8);
    align(7);
    step(1'b1, 8'hF0);
    step(1'b0, 8'h00);
    step(1'b1, 8'h0F);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    #1 reset = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    idle(8 * SYNC + 16);
    rand_steps(200);
    idle(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer8_com.md
Name: serializer8_com

Overview:
- Transmit-side parallel-to-serial stage that sits directly downstream of the 4-lane byte mux.
- Accepts the mux's 8-bit data + valid stream and shifts it out MSB-first, one bit per clock.
- Whenever no valid byte is available, it fills the line with the COM symbol. This keeps the serial stream continuously symbol-aligned for the receive-side deserializer.
- After reset it sends a fixed run of COM symbols (link sync) before accepting any data.

Parameters:
- COM_SYMBOL, 8'hBC, idle/sync filler symbol.
- SYNC_COUNT, 4, number of complete COM symbols sent after reset before ACTIVE; legal range 1..15.

Ports:
- clk  input  1  single clock, bit rate; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  8  byte from upstream mux.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block will accept in_data this cycle. A transfer occurs when in_valid & in_ready at a rising edge.
- ser_out  output  1  registered serial bit, MSB first.
- sym_start  output  1  registered; 1 while ser_out carries bit 7 of a symbol.
- active  output  1  registered; 1 once sync is complete (state ACTIVE).

Behaviour:
- Reset values (reset=0, async): ser_out=0, sym_start=0, active=0, state=SYNC, bitcnt=0, sync_cnt=0, shift register sh=COM_SYMBOL, holding buffer empty.
- in_ready is combinational. It is 0 whenever reset=0.
- Bit counter: 3-bit bitcnt increments every edge and wraps 7->0. It is never stalled.
- Every edge: ser_out <= sh[7-bitcnt]; sym_start <= (bitcnt==0).
  - First edge after release: ser_out=COM[7], sym_start=1.
- Symbol load happens on an edge with bitcnt==7. Priority:
  1. buffer full: sh <= buffer.
  2. else accept this cycle: sh <= in_data (bypass; buffer stays empty).
  3. else sh <= COM_SYMBOL.
- Holding buffer: 1 entry.
  - in_ready = (state==ACTIVE) & (buffer empty | bitcnt==7).
  - Accept with buffer full at bitcnt==7: buffer drains into sh and the new byte is written to the buffer in the same edge.
  - Accept with buffer empty and bitcnt!=7: byte is written to the buffer.
- FSM:
  - SYNC: in_ready=0. On each bitcnt==7 edge, sync_cnt increments. On the bitcnt==7 edge where sync_cnt==SYNC_COUNT-1, go to ACTIVE. The symbol loaded on that edge is COM.
  - ACTIVE: normal operation. Stays ACTIVE until reset.
  - active is registered from the next state, so active=1 after the SYNC->ACTIVE edge.
- Latency:
  - Bypass-accepted byte: bit7 appears on ser_out 1 edge after acceptance.
  - Buffered byte: bit7 appears 1 edge after the next bitcnt==7 edge.
- Throughput: at most one byte per 8 clocks. Continuous in_valid yields back-to-back data symbols with no COM gaps.
- Payload equal to COM_SYMBOL is sent unchanged (no escaping). active is unaffected.
- in_data and in_valid are ignored while in_ready=0. There is no requirement for upstream to hold them.
- Reset mid-operation:
  - Outputs go to reset values immediately; any buffered or partially shifted byte is discarded.
  - After release, the full SYNC sequence repeats.

Test Plan:
- Release reset, in_valid=0 -> ser_out repeats 1,0,1,1,1,1,0,0; sym_start=1 on edges 1,9,17,...; in_ready=0 and active=0 through edge 31; active=1 and in_ready=1 after edge 32; COM continues.
- In ACTIVE, present 0xA5 once with buffer empty at bitcnt=3 -> byte buffered, in_ready=0 until the bitcnt==7 cycle; ser_out then emits 1,0,1,0,0,1,0,1 with sym_start on the first bit; COM resumes afterwards.
- Bypass: buffer empty, in_valid=1 with 0x3C exactly in the bitcnt==7 cycle -> next edge ser_out=0 with sym_start=1, followed by 0,1,1,1,1,0,0.
- Stream 0x12,0x34,0x56 with in_valid held high -> three consecutive data symbols, no intervening COM, order preserved; in_ready pulses once per 8 clocks after the buffer fills.
- Reset low during bit 3 of 0xF0 with 0x0F buffered -> ser_out, sym_start, active and in_ready drop to 0 asynchronously; after release, SYNC_COUNT COMs are sent and neither 0xF0 remainder nor 0x0F ever appears.
- Payload 0xBC in ACTIVE -> transmitted bit-exact as 1,0,1,1,1,1,0,0; active stays 1; a following byte 0x00 is sent normally.
